// File: rtl/systolic_drain_requant.sv
// rtl/systolic_drain_requant.sv - capture a systolic accumulator tile and drain it row by row as requantized INT8
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             capture request, honoured only when idle
//   i_c_in              ROWS x COLS signed accumulators, sampled on the accepted start
//   i_scale_mult        signed requant multiplier, latched with start
//   i_scale_shift       rounding right shift (0..47), latched with start
//   i_zero_point        signed output offset, latched with start
//   o_busy              high while a tile is being drained
//   o_done              one-cycle pulse after the final row handshake
//   o_out_valid/i_out_ready   row handshake
//   o_out_data          COLS signed OUT_WIDTH lanes of the current row
//   o_out_row           row index of o_out_data
//   o_out_last          marks row ROWS-1
module systolic_drain_requant #(
    parameter int ROWS        = 32,
    parameter int COLS        = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int MULT_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 6,
    parameter int OUT_WIDTH   = 8,
    localparam int RW         = $clog2(ROWS)
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_start,
    input  logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0]  i_c_in,
    input  logic [MULT_WIDTH-1:0]                     i_scale_mult,
    input  logic [SHIFT_WIDTH-1:0]                    i_scale_shift,
    input  logic [OUT_WIDTH-1:0]                      i_zero_point,
    output logic                                      o_busy,
    output logic                                      o_done,
    output logic                                      o_out_valid,
    input  logic                                      i_out_ready,
    output logic [COLS-1:0][OUT_WIDTH-1:0]            o_out_data,
    output logic [RW-1:0]                             o_out_row,
    output logic                                      o_out_last
);

    localparam int PW = ACC_WIDTH + MULT_WIDTH;
    localparam logic [RW:0] PTR_ROWS = (RW+1)'(ROWS);
    localparam logic [RW:0] PTR_LAST = (RW+1)'(ROWS - 1);
    localparam logic signed [PW+1:0] SAT_MAX = $signed((PW+2)'((1 << (OUT_WIDTH-1)) - 1));
    localparam logic signed [PW+1:0] SAT_MIN = -SAT_MAX - 1;

    typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

    state_t r_state, w_state_nxt;
    logic   w_accept, w_final, w_adv, w_issue;

    // Private copy of the tile and its requant parameters
    logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0] r_buf;
    logic [MULT_WIDTH-1:0]                    r_mult;
    logic [SHIFT_WIDTH-1:0]                   r_shift;
    logic [OUT_WIDTH-1:0]                     r_zp;

    // Issue pointer is one bit wider so it can sit at ROWS once all rows are issued
    logic [RW:0]                 r_ptr;
    logic                        r_s1_valid;
    logic [RW-1:0]               r_s1_row;
    logic                        r_s1_last;
    logic [COLS-1:0][PW-1:0]     r_s1_p;
    logic [COLS-1:0][PW-1:0]     w_prod;
    logic [COLS-1:0][OUT_WIDTH-1:0] w_q;

    logic                        r_done;
    logic                        r_out_valid;
    logic [COLS-1:0][OUT_WIDTH-1:0] r_out_data;
    logic [RW-1:0]               r_out_row;
    logic                        r_out_last;

    // Rounding right shift (half toward +inf) at PW+1 bits, zero-point add, saturate
    function automatic logic [OUT_WIDTH-1:0] f_requant(
        input logic [PW-1:0]          p,
        input logic [SHIFT_WIDTH-1:0] sh,
        input logic [OUT_WIDTH-1:0]   zp
    );
        logic signed [PW:0]   v_rnd;
        logic signed [PW:0]   v_sum;
        logic signed [PW:0]   v_r;
        logic signed [PW+1:0] v_y;
        v_rnd = '0;
        if (sh != '0) begin
            v_rnd = $signed((PW+1)'(1) << (sh - SHIFT_WIDTH'(1)));
        end
        v_sum = $signed({p[PW-1], p}) + v_rnd;
        v_r   = v_sum >>> sh;
        v_y   = $signed({v_r[PW], v_r}) + (PW+2)'($signed(zp));
        if (v_y > SAT_MAX) begin
            v_y = SAT_MAX;
        end else if (v_y < SAT_MIN) begin
            v_y = SAT_MIN;
        end
        return v_y[OUT_WIDTH-1:0];
    endfunction

    // Whole pipeline moves together; a stalled output register freezes S1 and the pointer too
    assign w_adv   = !r_out_valid || i_out_ready;
    assign w_issue = (r_state == ST_DRAIN) && (r_ptr < PTR_ROWS);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_final     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_DRAIN;
                    w_accept    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_out_valid && i_out_ready && r_out_last) begin
                    w_state_nxt = ST_IDLE;
                    w_final     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_prod = '0;
        w_q    = '0;
        for (int j = 0; j < COLS; j++) begin
            w_prod[j] = PW'($signed(r_buf[r_ptr[RW-1:0]][j])) * PW'($signed(r_mult));
            w_q[j]    = f_requant(r_s1_p[j], r_shift, r_zp);
        end
    end

    // Capture storage carries no reset: it is only read after an accepted start refills it
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_buf   <= i_c_in;
            r_mult  <= i_scale_mult;
            r_shift <= i_scale_shift;
            r_zp    <= i_zero_point;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_row    <= '0;
            r_s1_last   <= 1'b0;
            r_s1_p      <= '0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_done <= w_final;
            if (w_accept) begin
                r_ptr <= '0;
            end
            if (w_adv) begin
                r_s1_valid <= w_issue;
                if (w_issue) begin
                    r_s1_p    <= w_prod;
                    r_s1_row  <= r_ptr[RW-1:0];
                    r_s1_last <= (r_ptr == PTR_LAST);
                    r_ptr     <= r_ptr + 1'b1;
                end
                r_out_valid <= r_s1_valid;
                r_out_last  <= r_s1_valid && r_s1_last;
                if (r_s1_valid) begin
                    r_out_data <= w_q;
                    r_out_row  <= r_s1_row;
                end
            end
        end
    end

    assign o_busy      = (r_state == ST_DRAIN);
    assign o_done      = r_done;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_row   = r_out_row;
    assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_systolic_drain_requant.sv
// tb/tb_systolic_drain_requant.sv - randomized self-checking bench for systolic_drain_requant
module tb_systolic_drain_requant;

    localparam int ROWS = 32;
    localparam int COLS = 16;
    localparam int AW   = 32;
    localparam int MW   = 16;
    localparam int SW   = 6;
    localparam int OW   = 8;
    localparam int RW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                             reset;
    logic                             start;
    logic [ROWS-1:0][COLS-1:0][AW-1:0] c_in;
    logic [MW-1:0]                    mult;
    logic [SW-1:0]                    shift;
    logic [OW-1:0]                    zp;
    logic                             busy;
    logic                             done;
    logic                             out_valid;
    logic                             out_ready;
    logic [COLS-1:0][OW-1:0]          out_data;
    logic [RW-1:0]                    out_row;
    logic                             out_last;

    systolic_drain_requant dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_c_in        (c_in),
        .i_scale_mult  (mult),
        .i_scale_shift (shift),
        .i_zero_point  (zp),
        .o_busy        (busy),
        .o_done        (done),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_out_row     (out_row),
        .o_out_last    (out_last)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [COLS-1:0][OW-1:0] exp_row [ROWS];
    logic [COLS-1:0][OW-1:0] row0;

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] ref_q(input longint acc, input longint m, input int sh, input longint z);
        longint p, r, y, one;
        one = 1;
        p = acc * m;
        if (sh > 0) r = (p + (one << (sh - 1))) >>> sh;
        else        r = p;
        y = r + z;
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y[OW-1:0];
    endfunction

    task automatic rand_cin();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                c_in[i][j] = $urandom;
    endtask

    task automatic rand_params();
        mult  = MW'($urandom);
        zp    = OW'($urandom);
        shift = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 47)) : SW'($urandom_range(20, 40));
        rand_cin();
    endtask

    // Snapshot the expected tile, pulse start across one edge, then disturb c_in
    task automatic start_tile();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                exp_row[i][j] = ref_q(longint'($signed(c_in[i][j])), longint'($signed(mult)),
                                      int'(shift), longint'($signed(zp)));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rand_cin();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drain a tile: duty = ready percentage, stall0 = ready held low this many cycles after first valid,
    // mid = cycle to pulse start mid-drain (-1 none), max_beats = stop early after that many beats (0 = all)
    task automatic collect(input int duty, input int stall0, input bit lat, input int mid, input int max_beats);
        int cyc = 0;
        int nxt = 0;
        int first = -1;
        bit held = 0;
        bit fin = 0;
        logic [COLS-1:0][OW-1:0] hd;
        logic [RW-1:0] hr;
        logic hl;
        while (!fin && cyc < 3000) begin
            if (stall0 > 0 && (first < 0 || cyc < first + stall0)) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 99) < duty);
            if (mid >= 0) begin
                start = (cyc == mid);
                if (cyc == mid) rand_cin();
            end
            @(negedge clk);
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_row", out_row, hr);
                chk("hold_data", out_data, hd);
                chk("hold_last", out_last, hl);
                if (stall0 > 0) chk("hold_busy", busy, 1);
            end
            if (out_valid) begin
                if (first < 0) begin
                    first = cyc;
                    if (lat) chk("first_latency", cyc, 2);
                end
                if (!held) begin
                    chk("row", out_row, nxt[RW-1:0]);
                    if (nxt < ROWS) chk("data", out_data, exp_row[nxt]);
                    chk("last", out_last, (nxt == ROWS - 1));
                    if (lat && duty >= 100 && stall0 == 0) chk("cadence", cyc, 2 + nxt);
                    if (nxt == 0) row0 = out_data;
                end
                if (out_ready) begin
                    held = 0;
                    if (out_last) fin = 1;
                    nxt++;
                    if (max_beats > 0 && nxt == max_beats) fin = 1;
                end else begin
                    held = 1;
                    hd = out_data;
                    hr = out_row;
                    hl = out_last;
                end
            end else begin
                held = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!fin) chk("timeout_beats", nxt, ROWS);
        if (fin && max_beats == 0) begin
            @(negedge clk);
            chk("done_pulse", done, 1);
            chk("busy_after", busy, 0);
            chk("valid_after", out_valid, 0);
        end
    endtask

    int dc0;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        c_in = '0;
        mult = '0;
        shift = '0;
        zp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        // Identity tile
        mult = 16'd1; shift = '0; zp = '0;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                c_in[i][j] = AW'(i - j);
        dc0 = done_cnt;
        start_tile();
        collect(100, 0, 1, -1, 0);
        idle(3);
        chk("id_done_count", done_cnt - dc0, 1);
        chk("id_r0_l1", row0[1], 8'hff);
        chk("id_r0_l0", row0[0], 8'h00);

        // Rounding half toward +inf
        rand_cin(); mult = 16'd1; shift = 6'd1; zp = '0;
        c_in[0][0] = 32'd3; c_in[0][1] = -32'sd3;
        start_tile();
        collect(40, 0, 0, -1, 0);
        idle(2);
        chk("rnd_p3", row0[0], 8'd2);
        chk("rnd_m3", row0[1], 8'hff);

        rand_cin(); mult = 16'd3; shift = 6'd2; zp = '0;
        c_in[0][0] = 32'd5;
        start_tile();
        collect(100, 0, 0, -1, 0);
        idle(2);
        chk("rnd_5x3", row0[0], 8'd4);

        // Saturation and zero point
        rand_cin(); mult = 16'd1; shift = '0; zp = '0;
        c_in[0][0] = 32'd1000; c_in[0][1] = -32'sd1000;
        start_tile();
        collect(60, 0, 0, -1, 0);
        idle(2);
        chk("sat_hi", row0[0], 8'h7f);
        chk("sat_lo", row0[1], 8'h80);

        rand_cin(); mult = 16'd1; shift = '0; zp = 8'd10;
        c_in[0][0] = 32'd120;
        start_tile();
        collect(100, 0, 0, -1, 0);
        idle(2);
        chk("zp_sat", row0[0], 8'h7f);

        rand_cin(); mult = 16'd1; shift = '0; zp = -8'sd5;
        c_in[0][0] = 32'd0;
        start_tile();
        collect(100, 0, 0, -1, 0);
        idle(2);
        chk("zp_neg", row0[0], 8'hfb);

        // Random tiles under random backpressure
        for (int t = 0; t < 3; t++) begin
            rand_params();
            dc0 = done_cnt;
            start_tile();
            collect(40, 0, 0, -1, 0);
            idle(2);
            chk("bp_done_count", done_cnt - dc0, 1);
        end

        // Ten-cycle stall right after the first valid beat
        rand_params();
        start_tile();
        collect(100, 10, 1, -1, 0);
        idle(2);

        // Start mid-drain is ignored; start in the done cycle launches the next tile
        rand_params();
        dc0 = done_cnt;
        start_tile();
        collect(100, 0, 1, 6, 0);
        rand_params();
        start_tile();
        collect(100, 0, 1, -1, 0);
        idle(3);
        chk("ovl_done_count", done_cnt - dc0, 2);

        // Reset after five beats aborts the tile
        rand_params();
        dc0 = done_cnt;
        start_tile();
        collect(100, 0, 0, -1, 5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        idle(6);
        chk("abort_no_done", done_cnt - dc0, 0);

        rand_params();
        dc0 = done_cnt;
        start_tile();
        collect(60, 0, 0, -1, 0);
        idle(3);
        chk("fresh_done_count", done_cnt - dc0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
